// File: rtl/vcfg_unit_pkg.sv
// Shared encodings for the vector-configuration unit: opcode fields, vtype layout,
// FSM states and the instruction-form decoder used at accept time.
package vcfg_unit_pkg;

    localparam logic [6:0] VR_FORMAT = 7'b1010111;
    localparam logic [2:0] VC_FORMAT = 3'b111;

    localparam int VTYPE_VLMUL_LSB = 0;
    localparam int VTYPE_VSEW_LSB  = 3;
    localparam int VTYPE_VTA_BIT   = 6;
    localparam int VTYPE_VMA_BIT   = 7;
    localparam int VTYPE_RSVD_LSB  = 8;

    localparam logic [2:0] VLMUL_RSVD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } vcfgState_t;

    typedef enum logic [1:0] {
        FORM_NONE     = 2'd0,
        FORM_VSETVLI  = 2'd1,
        FORM_VSETIVLI = 2'd2,
        FORM_VSETVL   = 2'd3
    } vcfgForm_t;

    // Encodings outside the three vset* forms map to FORM_NONE and are never accepted.
    function automatic vcfgForm_t decodeForm(input logic [31:0] instr);
        vcfgForm_t form;
        form = FORM_NONE;
        if (instr[6:0] == VR_FORMAT && instr[14:12] == VC_FORMAT) begin
            if (!instr[31]) begin
                form = FORM_VSETVLI;
            end else if (instr[30]) begin
                form = FORM_VSETIVLI;
            end else if (instr[29:25] == 5'b00000) begin
                form = FORM_VSETVL;
            end
        end
        return form;
    endfunction

endpackage

// File: rtl/vcfg_unit_vlmax_calc.sv
// Combinational VLMAX and vtype legality: VLMAX = (VLEN/SEW)*LMUL built purely from shifts.
module vcfg_unit_vlmax_calc
    import vcfg_unit_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int VL_W = $clog2(VLEN + 1)
) (
    input  logic [2:0]      i_vsew,
    input  logic [2:0]      i_vlmul,
    input  logic            i_rsvd,
    output logic [VL_W-1:0] o_vlmax,
    output logic            o_legal
);

    localparam logic [3:0] ELEN_LOG2 = 4'($clog2(ELEN));

    logic [3:0]  w_sewLog2;
    logic [2:0]  w_fracShift;
    logic        w_frac;
    logic [31:0] w_base;
    logic [31:0] w_scaled;
    logic        w_sewBad;
    logic        w_lmulBad;

    // Fractional LMUL 1/2^k is encoded as 8-k, so the right-shift amount is -vlmul mod 8.
    always_comb begin
        w_sewLog2   = 4'd3 + {1'b0, i_vsew};
        w_frac      = i_vlmul[2] & (i_vlmul[1:0] != 2'b00);
        w_fracShift = 3'd0 - i_vlmul;
        w_base      = 32'(VLEN) >> w_sewLog2;
        w_scaled    = w_frac ? (w_base >> w_fracShift) : (w_base << i_vlmul[1:0]);
        w_sewBad    = i_vsew[2] | (w_sewLog2 > ELEN_LOG2);
        w_lmulBad   = (i_vlmul == VLMUL_RSVD)
                    | (w_frac & ((({1'b0, w_sewLog2} + {2'b00, w_fracShift}) > {1'b0, ELEN_LOG2})
                                 | (w_scaled == 32'd0)));
        o_legal     = ~i_rsvd & ~w_sewBad & ~w_lmulBad;
        o_vlmax     = o_legal ? w_scaled[VL_W-1:0] : '0;
    end

endmodule

// File: rtl/vcfg_unit.sv
// Sequential vset{i}vl{i} unit: captures operands, computes vl/vtype, waits for the vector
// pipe to drain, then writes vl back to rd and updates the vl/vtype CSRs.
module vcfg_unit
    import vcfg_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    localparam int VL_W = $clog2(VLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            vec_busy,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [VL_W-1:0] csr_vl,
    output logic [2:0]      csr_vsew,
    output logic [2:0]      csr_vlmul,
    output logic            csr_vta,
    output logic            csr_vma,
    output logic            csr_vill,
    output logic [VL_W-1:0] csr_vlmax
);

    vcfgState_t      r_state;
    vcfgForm_t       r_form;
    logic [XLEN-1:0] r_vtype;
    logic [XLEN-1:0] r_rs1Data;
    logic [4:0]      r_rs1Idx;
    logic [4:0]      r_rd;
    logic            r_inReady;
    logic            r_wbValid;

    logic [VL_W-1:0] r_newVl;
    logic [VL_W-1:0] r_newVlmax;
    logic [2:0]      r_newVsew;
    logic [2:0]      r_newVlmul;
    logic            r_newVta;
    logic            r_newVma;
    logic            r_newVill;

    logic [VL_W-1:0] r_vl;
    logic [VL_W-1:0] r_vlmax;
    logic [2:0]      r_vsew;
    logic [2:0]      r_vlmul;
    logic            r_vta;
    logic            r_vma;
    logic            r_vill;

    vcfgForm_t       w_inForm;
    logic [XLEN-1:0] w_inVtype;
    logic            w_rsvd;
    logic            w_unusedVtypeMsb;
    logic [VL_W-1:0] w_vlmax;
    logic            w_typeLegal;
    logic            w_keepVl;
    logic [XLEN-1:0] w_avl;
    logic            w_legal;
    logic [VL_W-1:0] w_newVl;

    assign w_inForm = decodeForm(in_instr);

    always_comb begin
        w_inVtype = '0;
        case (w_inForm)
            FORM_VSETVLI:  w_inVtype = XLEN'(in_instr[30:20]);
            FORM_VSETIVLI: w_inVtype = XLEN'(in_instr[29:20]);
            FORM_VSETVL:   w_inVtype = in_rs2_data;
            default:       w_inVtype = '0;
        endcase
    end

    // The top vtype bit is the vill position; a value written through rs2 there is ignored.
    assign w_rsvd           = |r_vtype[XLEN-2:VTYPE_RSVD_LSB];
    assign w_unusedVtypeMsb = r_vtype[XLEN-1];

    vcfg_unit_vlmax_calc #(
        .VLEN (VLEN),
        .ELEN (ELEN),
        .VL_W (VL_W)
    ) u_vlmaxCalc (
        .i_vsew  (r_vtype[VTYPE_VSEW_LSB+:3]),
        .i_vlmul (r_vtype[VTYPE_VLMUL_LSB+:3]),
        .i_rsvd  (w_rsvd),
        .o_vlmax (w_vlmax),
        .o_legal (w_typeLegal)
    );

    // rs1=rd=x0 keeps the current vl, which is only meaningful if VLMAX does not change.
    always_comb begin
        w_keepVl = (r_form != FORM_VSETIVLI) && (r_rs1Idx == 5'd0) && (r_rd == 5'd0);
        if (r_form == FORM_VSETIVLI) begin
            w_avl = XLEN'(r_rs1Idx);
        end else if (r_rs1Idx != 5'd0) begin
            w_avl = r_rs1Data;
        end else begin
            w_avl = '1;
        end
        w_legal = w_typeLegal & ~(w_keepVl & (r_vill | (w_vlmax != r_vlmax)));
        if (!w_legal) begin
            w_newVl = '0;
        end else if (w_keepVl) begin
            w_newVl = r_vl;
        end else if (w_avl >= XLEN'(w_vlmax)) begin
            w_newVl = w_vlmax;
        end else begin
            w_newVl = w_avl[VL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_form     <= FORM_NONE;
            r_vtype    <= '0;
            r_rs1Data  <= '0;
            r_rs1Idx   <= '0;
            r_rd       <= '0;
            r_inReady  <= 1'b1;
            r_wbValid  <= 1'b0;
            r_newVl    <= '0;
            r_newVlmax <= '0;
            r_newVsew  <= '0;
            r_newVlmul <= '0;
            r_newVta   <= 1'b0;
            r_newVma   <= 1'b0;
            r_newVill  <= 1'b1;
            r_vl       <= '0;
            r_vlmax    <= '0;
            r_vsew     <= '0;
            r_vlmul    <= '0;
            r_vta      <= 1'b0;
            r_vma      <= 1'b0;
            r_vill     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && w_inForm != FORM_NONE) begin
                        r_form    <= w_inForm;
                        r_vtype   <= w_inVtype;
                        r_rs1Data <= in_rs1_data;
                        r_rs1Idx  <= in_instr[19:15];
                        r_rd      <= in_instr[11:7];
                        r_inReady <= 1'b0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_newVl    <= w_newVl;
                    r_newVlmax <= w_vlmax;
                    r_newVsew  <= w_legal ? r_vtype[VTYPE_VSEW_LSB+:3] : 3'd0;
                    r_newVlmul <= w_legal ? r_vtype[VTYPE_VLMUL_LSB+:3] : 3'd0;
                    r_newVta   <= w_legal & r_vtype[VTYPE_VTA_BIT];
                    r_newVma   <= w_legal & r_vtype[VTYPE_VMA_BIT];
                    r_newVill  <= ~w_legal;
                    if (!w_legal) begin
                        r_newVlmax <= '0;
                    end
                    if (vec_busy) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_wbValid <= 1'b1;
                        r_state   <= ST_COMMIT;
                    end
                end
                ST_DRAIN: begin
                    if (!vec_busy) begin
                        r_wbValid <= 1'b1;
                        r_state   <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_vl      <= r_newVl;
                    r_vlmax   <= r_newVlmax;
                    r_vsew    <= r_newVsew;
                    r_vlmul   <= r_newVlmul;
                    r_vta     <= r_newVta;
                    r_vma     <= r_newVma;
                    r_vill    <= r_newVill;
                    r_wbValid <= 1'b0;
                    r_inReady <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign wb_valid  = r_wbValid;
    assign wb_rd     = r_rd;
    assign wb_data   = XLEN'(r_newVl);
    assign csr_vl    = r_vl;
    assign csr_vlmax = r_vlmax;
    assign csr_vsew  = r_vsew;
    assign csr_vlmul = r_vlmul;
    assign csr_vta   = r_vta;
    assign csr_vma   = r_vma;
    assign csr_vill  = r_vill;

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed and randomized vset* sequences checked against an arithmetic model of vl/vtype.
module tb_vcfg_unit;

    localparam int XLEN = 32;
    localparam int VLEN = 128;
    localparam int ELEN = 64;
    localparam int VL_W = $clog2(VLEN + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_rs1_data = '0;
    logic [XLEN-1:0] in_rs2_data = '0;
    logic            vec_busy = 1'b0;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [VL_W-1:0] csr_vl;
    logic [2:0]      csr_vsew;
    logic [2:0]      csr_vlmul;
    logic            csr_vta;
    logic            csr_vma;
    logic            csr_vill;
    logic [VL_W-1:0] csr_vlmax;

    int checkCount = 0;
    int passCount  = 0;

    longint mVl, mVlmax, mVsew, mVlmul, mVta, mVma, mVill;
    longint pVl, pVlmax, pVsew, pVlmul, pVta, pVma, pVill;

    vcfg_unit #(
        .XLEN (XLEN),
        .VLEN (VLEN),
        .ELEN (ELEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .vec_busy    (vec_busy),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .csr_vl      (csr_vl),
        .csr_vsew    (csr_vsew),
        .csr_vlmul   (csr_vlmul),
        .csr_vta     (csr_vta),
        .csr_vma     (csr_vma),
        .csr_vill    (csr_vill),
        .csr_vlmax   (csr_vlmax)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            $display("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    function automatic logic [31:0] mkVsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mkVsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mkVsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    task automatic modelReset();
        mVl = 0; mVlmax = 0; mVsew = 0; mVlmul = 0; mVta = 0; mVma = 0; mVill = 1;
    endtask

    // Reference: SEW and LMUL as plain numbers, VLMAX by division, vl as min(AVL, VLMAX).
    task automatic modelPredict(input logic [31:0] instr, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, output logic [63:0] eRd,
                                output logic [63:0] eData);
        logic [31:0] vt;
        logic [4:0]  rs1Idx;
        logic [4:0]  rdIdx;
        int          vsew, vlmul, sew, num, den;
        longint      vlmax, avl, vl;
        bit          legal, keep, isImm;
        rs1Idx = instr[19:15];
        rdIdx  = instr[11:7];
        isImm  = 0;
        if (instr[31] == 1'b0) begin
            vt = {21'd0, instr[30:20]};
        end else if (instr[30] == 1'b1) begin
            vt = {22'd0, instr[29:20]};
            isImm = 1;
        end else begin
            vt = rs2d;
        end
        vsew  = int'(vt[5:3]);
        vlmul = int'(vt[2:0]);
        sew   = 8 << vsew;
        legal = (vt[30:8] == 23'd0) && (vsew < 4) && (sew <= ELEN) && (vlmul != 4);
        if (vlmul < 4) begin
            num = 1 << vlmul;
            den = 1;
        end else begin
            num = 1;
            den = 1 << (8 - vlmul);
        end
        if (den > 1 && sew * den > ELEN) legal = 0;
        vlmax = longint'((VLEN * num) / (sew * den));
        if (den > 1 && vlmax == 0) legal = 0;
        keep = 0;
        avl  = 0;
        if (isImm) avl = longint'(rs1Idx);
        else if (rs1Idx != 5'd0) avl = longint'({32'd0, rs1d});
        else if (rdIdx != 5'd0) avl = 64'h0000_0000_FFFF_FFFF;
        else begin
            keep = 1;
            if (mVill != 0 || vlmax != mVlmax) legal = 0;
        end
        vl = keep ? mVl : ((avl >= vlmax) ? vlmax : avl);
        if (legal) begin
            pVl = vl; pVlmax = vlmax; pVsew = vsew; pVlmul = vlmul;
            pVta = longint'(vt[6]); pVma = longint'(vt[7]); pVill = 0;
        end else begin
            pVl = 0; pVlmax = 0; pVsew = 0; pVlmul = 0; pVta = 0; pVma = 0; pVill = 1;
        end
        eRd   = 64'(rdIdx);
        eData = 64'(pVl);
    endtask

    task automatic checkCsrs();
        checkOutput("csrVl",    64'(csr_vl),    64'(mVl));
        checkOutput("csrVlmax", 64'(csr_vlmax), 64'(mVlmax));
        checkOutput("csrVsew",  64'(csr_vsew),  64'(mVsew));
        checkOutput("csrVlmul", 64'(csr_vlmul), 64'(mVlmul));
        checkOutput("csrVta",   64'(csr_vta),   64'(mVta));
        checkOutput("csrVma",   64'(csr_vma),   64'(mVma));
        checkOutput("csrVill",  64'(csr_vill),  64'(mVill));
    endtask

    // One full op from IDLE: vec_busy stays high for `busy` cycles after the accept edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs1d,
                                 input logic [31:0] rs2d, input int busy);
        logic [63:0] eRd;
        logic [63:0] eData;
        int          k;
        modelPredict(instr, rs1d, rs2d, eRd, eData);
        checkOutput("readyIdle", 64'(in_ready), 64'(1));
        in_instr    = instr;
        in_rs1_data = rs1d;
        in_rs2_data = rs2d;
        in_valid    = 1'b1;
        vec_busy    = (busy > 0);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_instr    = $urandom;
        in_rs1_data = $urandom;
        in_rs2_data = $urandom;
        k = 0;
        while (wb_valid !== 1'b1 && k < 40) begin
            checkOutput("readyInFlight", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            k++;
            vec_busy = (k < busy);
        end
        checkOutput("latency", 64'(k), 64'((busy == 0) ? 1 : busy + 1));
        checkOutput("wbRd", 64'(wb_rd), eRd);
        checkOutput("wbData", 64'(wb_data), eData);
        checkOutput("readyCommit", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        vec_busy = 1'b0;
        checkOutput("wbPulse", 64'(wb_valid), 64'(0));
        checkOutput("readyAfter", 64'(in_ready), 64'(1));
        mVl = pVl; mVlmax = pVlmax; mVsew = pVsew; mVlmul = pVlmul;
        mVta = pVta; mVma = pVma; mVill = pVill;
        checkCsrs();
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [10:0] zimm;
        logic [4:0]  rd;
        logic [4:0]  rs1;

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReadyHeld", 64'(in_ready), 64'(1));
        checkOutput("rstWbHeld", 64'(wb_valid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkCsrs();

        applyStimulus(mkVsetvli(5'd5, 5'd6, 11'h011), 32'd100, 32'd0, 0);
        checkOutput("e32m2VlConst", 64'(csr_vl), 64'(8));
        applyStimulus(mkVsetvli(5'd0, 5'd0, 11'h008), 32'd0, 32'd0, 0);
        checkOutput("keepVlConst", 64'(csr_vl), 64'(8));
        applyStimulus(mkVsetvli(5'd5, 5'd6, 11'h011), 32'd100, 32'd0, 0);
        applyStimulus(mkVsetvli(5'd0, 5'd0, 11'h00A), 32'd0, 32'd0, 0);
        checkOutput("keepVlmaxChangeVill", 64'(csr_vill), 64'(1));
        applyStimulus(mkVsetivli(5'd3, 5'd3, 10'h000), 32'd0, 32'd0, 0);
        checkOutput("ivliVlmaxConst", 64'(csr_vlmax), 64'(16));
        applyStimulus(mkVsetvl(5'd2, 5'd6, 5'd7), 32'd100, 32'h0000_00C8, 0);
        applyStimulus(mkVsetvli(5'd1, 5'd0, 11'h00F), 32'd0, 32'd0, 0);
        checkOutput("mf2VlConst", 64'(csr_vl), 64'(4));
        applyStimulus(mkVsetvli(5'd1, 5'd6, 11'h01D), 32'd50, 32'd0, 0);
        applyStimulus(mkVsetvli(5'd1, 5'd6, 11'h020), 32'd50, 32'd0, 0);
        applyStimulus(mkVsetvli(5'd5, 5'd6, 11'h011), 32'd100, 32'd0, 5);

        in_instr = {7'b1000001, 5'd3, 5'd4, 3'b111, 5'd5, 7'b1010111};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("ignoredReady", 64'(in_ready), 64'(1));
            checkOutput("ignoredNoWb", 64'(wb_valid), 64'(0));
            @(posedge clk); #1;
        end
        checkCsrs();

        for (int n = 0; n < 40; n++) begin
            zimm = 11'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) zimm[5:3] = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) zimm[10:8] = 3'($urandom_range(1, 7));
            rd   = 5'($urandom_range(0, 3));
            rs1  = 5'($urandom_range(0, 3));
            rs1d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rs2d = {21'd0, zimm};
            if ($urandom_range(0, 7) == 0) rs2d[30:8] = 23'($urandom);
            case ($urandom_range(0, 2))
                0:       instr = mkVsetvli(rd, rs1, zimm);
                1:       instr = mkVsetivli(rd, 5'($urandom), zimm[9:0]);
                default: instr = mkVsetvl(rd, rs1, 5'd9);
            endcase
            applyStimulus(instr, rs1d, rs2d, $urandom_range(0, 3));
        end

        in_instr    = mkVsetvli(5'd7, 5'd6, 11'h008);
        in_rs1_data = 32'd5;
        in_valid    = 1'b1;
        vec_busy    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("drainNoWb", 64'(wb_valid), 64'(0));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        vec_busy = 1'b0;
        checkOutput("rstDrainNoWb", 64'(wb_valid), 64'(0));
        checkOutput("rstDrainReady", 64'(in_ready), 64'(1));
        modelReset();
        checkCsrs();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("rstDrainQuiet", 64'(wb_valid), 64'(0));
        end
        checkCsrs();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
